// File: rtl/mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_unit
// Purpose  : Iterative shift-add multiplier for the EX stage. A start strobe
//            latches the operand magnitudes and the result sign, WIDTH
//            shift-add iterations build the magnitude product, and the signed
//            2*WIDTH-bit result is written to Hi/Lo. ProdV then pulses for
//            one cycle.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous active-high reset, clears all state
//            MultStart  - start strobe (mult/multu)
//            MultSigned - 1 = signed, 0 = unsigned; sampled with MultStart
//            Cancel     - abort an in-flight op; also blocks a start in IDLE
//            SrcAE      - multiplicand, sampled with MultStart
//            SrcBE      - multiplier, sampled with MultStart
//            ProdV      - product valid, one-cycle pulse (DONE state)
//            Busy       - high in RUN and DONE
//            Hi / Lo    - upper / lower product half, held until next result
// Revision : 1.0 - initial release
// ============================================================================
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultStart,
  input  logic             MultSigned,
  input  logic             Cancel,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             ProdV,
  output logic             Busy,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int                 CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W    = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W   = (2*WIDTH)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  // The multiplicand is kept pre-shifted in a 2*WIDTH register and moved one
  // place left per iteration, which equals adding mcand<<cnt without a shifter.
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q,   acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q,   cnt_d;
  logic               neg_q,   neg_d;
  logic [WIDTH-1:0]   hi_q,    hi_d;
  logic [WIDTH-1:0]   lo_q,    lo_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_final;

  // Magnitudes. The most-negative operand negates to itself, which read as
  // unsigned is exactly its magnitude, so no special case is required.
  assign abs_a = (MultSigned && SrcAE[WIDTH-1]) ? (~SrcAE + ONE_W) : SrcAE;
  assign abs_b = (MultSigned && SrcBE[WIDTH-1]) ? (~SrcBE + ONE_W) : SrcBE;

  assign acc_next   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign prod_final = neg_q ? (~acc_next + ONE_2W) : acc_next;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      S_IDLE: begin
        if (MultStart && !Cancel) begin
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          neg_d    = MultSigned & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (Cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            {hi_d, lo_d} = prod_final;
            state_d      = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign ProdV = (state_q == S_DONE);
  assign Busy  = (state_q == S_RUN) || (state_q == S_DONE);
  assign Hi    = hi_q;
  assign Lo    = lo_q;

endmodule
`default_nettype wire
